// File: rtl/pokemon_pkg.sv
// Shared overworld types: facing direction, HID movement keys, step FSM states
// and the key decode / direction delta helpers.
package pokemon_pkg;

    typedef enum logic [1:0] {
        DIR_DOWN  = 2'b00,
        DIR_UP    = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_t;

    localparam logic [7:0] KEY_W = 8'h1A;
    localparam logic [7:0] KEY_A = 8'h04;
    localparam logic [7:0] KEY_S = 8'h16;
    localparam logic [7:0] KEY_D = 8'h07;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_QUERY = 2'b01,
        ST_STEP  = 2'b10
    } step_state_t;

    typedef struct packed {
        logic valid;
        dir_t dir;
    } key_dec_t;

    function automatic key_dec_t decode_key(input logic [7:0] kc);
        key_dec_t r;
        case (kc)
            KEY_W:   begin r.valid = 1'b1; r.dir = DIR_UP;    end
            KEY_S:   begin r.valid = 1'b1; r.dir = DIR_DOWN;  end
            KEY_A:   begin r.valid = 1'b1; r.dir = DIR_LEFT;  end
            KEY_D:   begin r.valid = 1'b1; r.dir = DIR_RIGHT; end
            default: begin r.valid = 1'b0; r.dir = DIR_DOWN;  end
        endcase
        return r;
    endfunction

    // Signed 7-bit column delta so a step off the left edge becomes -1.
    function automatic logic signed [6:0] dir_dx(input dir_t d);
        case (d)
            DIR_LEFT:  return -7'sd1;
            DIR_RIGHT: return 7'sd1;
            default:   return 7'sd0;
        endcase
    endfunction

    function automatic logic signed [6:0] dir_dy(input dir_t d);
        case (d)
            DIR_UP:   return -7'sd1;
            DIR_DOWN: return 7'sd1;
            default:  return 7'sd0;
        endcase
    endfunction

endpackage

// File: rtl/overworld_step_ctrl_if.sv
// Collision lookup request/acknowledge handshake between the step scheduler
// and the tile map.
interface overworld_step_ctrl_if;
    logic       coll_req;
    logic [5:0] coll_x;
    logic [4:0] coll_y;
    logic       coll_ack;
    logic       coll_blocked;

    modport master (
        output coll_req,
        output coll_x,
        output coll_y,
        input  coll_ack,
        input  coll_blocked
    );

    modport slave (
        input  coll_req,
        input  coll_x,
        input  coll_y,
        output coll_ack,
        output coll_blocked
    );
endinterface

// File: rtl/vs_tick_gen.sv
// Turns the raw active-low vertical sync into a one-clock frame tick at the
// end of each sync pulse.
module vs_tick_gen (
    input  logic clk,
    input  logic rst_n,
    input  logic vs,
    output logic tick
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;
    logic tick_q,  tick_d;

    // Next-state: two-stage synchroniser, history flop and rising-edge detect.
    always_comb begin
        sync1_d = vs;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        tick_d  = sync2_q & ~prev_q;
    end

    // Flops reset high so leaving reset never looks like a rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            tick_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            tick_q  <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/overworld_step_ctrl.sv
// Tile-stepping movement scheduler: samples the key once per frame, checks the
// target tile for collision, then slides the sprite one tile over STEP_PIXELS frames.
module overworld_step_ctrl
    import pokemon_pkg::*;
#(
    parameter int unsigned STEP_PIXELS = 16,
    parameter int unsigned MAP_W       = 40,
    parameter int unsigned MAP_H       = 30,
    parameter int unsigned START_X     = 10,
    parameter int unsigned START_Y     = 7
) (
    input  logic                         Clk,
    input  logic                         Reset_n,
    input  logic                         vs,
    input  logic [7:0]                   keycode,
    overworld_step_ctrl_if.master        coll,
    output logic [5:0]                   tile_x,
    output logic [4:0]                   tile_y,
    output logic [9:0]                   pos_x,
    output logic [9:0]                   pos_y,
    output logic [1:0]                   Direction,
    output logic                         Character_Moving,
    output logic [1:0]                   walk_frame
);

    localparam int unsigned OFF_W = $clog2(STEP_PIXELS);
    localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(STEP_PIXELS - 1);

    step_state_t       state_q,    state_d;
    logic [5:0]        tile_x_q,   tile_x_d;
    logic [4:0]        tile_y_q,   tile_y_d;
    logic [5:0]        tgt_x_q,    tgt_x_d;
    logic [4:0]        tgt_y_q,    tgt_y_d;
    logic [OFF_W-1:0]  offset_q,   offset_d;
    dir_t              dir_q,      dir_d;
    logic              moving_q,   moving_d;
    logic              coll_req_q, coll_req_d;
    logic [9:0]        pos_x_q,    pos_x_d;
    logic [9:0]        pos_y_q,    pos_y_d;
    logic [1:0]        walk_q,     walk_d;

    logic              tick_s;
    key_dec_t          key_s;
    logic signed [6:0] tgt_col_s;
    logic signed [6:0] tgt_row_s;
    logic              in_range_s;
    logic [9:0]        base_x_s;
    logic [9:0]        base_y_s;
    logic [9:0]        off_ext_s;

    vs_tick_gen u_vs_tick_gen (
        .clk   (Clk),
        .rst_n (Reset_n),
        .vs    (vs),
        .tick  (tick_s)
    );

    assign key_s      = decode_key(keycode);
    assign tgt_col_s  = $signed({1'b0, tile_x_q}) + dir_dx(key_s.dir);
    assign tgt_row_s  = $signed({2'b00, tile_y_q}) + dir_dy(key_s.dir);
    assign in_range_s = !tgt_col_s[6] && ($unsigned(tgt_col_s) < 7'(MAP_W)) &&
                        !tgt_row_s[6] && ($unsigned(tgt_row_s) < 7'(MAP_H));

    assign base_x_s  = {4'b0000, tile_x_q} << OFF_W;
    assign base_y_s  = {5'b00000, tile_y_q} << OFF_W;
    assign off_ext_s = 10'(offset_q);

    // Next-state logic for the IDLE/QUERY/STEP scheduler and the pixel outputs.
    always_comb begin
        state_d    = state_q;
        tile_x_d   = tile_x_q;
        tile_y_d   = tile_y_q;
        tgt_x_d    = tgt_x_q;
        tgt_y_d    = tgt_y_q;
        offset_d   = offset_q;
        dir_d      = dir_q;
        moving_d   = moving_q;
        coll_req_d = coll_req_q;

        case (state_q)
            ST_IDLE: begin
                if (tick_s && key_s.valid) begin
                    dir_d = key_s.dir;
                    if (in_range_s) begin
                        state_d    = ST_QUERY;
                        tgt_x_d    = tgt_col_s[5:0];
                        tgt_y_d    = tgt_row_s[4:0];
                        coll_req_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_QUERY: begin
                if (coll.coll_ack) begin
                    coll_req_d = 1'b0;
                    if (coll.coll_blocked) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d  = ST_STEP;
                        offset_d = '0;
                        moving_d = 1'b1;
                    end
                end else begin
                    state_d = ST_QUERY;
                end
            end
            ST_STEP: begin
                if (tick_s) begin
                    if (offset_q == OFF_LAST) begin
                        // Tile and offset move together so pos never jumps.
                        state_d  = ST_IDLE;
                        tile_x_d = tgt_x_q;
                        tile_y_d = tgt_y_q;
                        offset_d = '0;
                        moving_d = 1'b0;
                    end else begin
                        offset_d = offset_q + OFF_W'(1);
                    end
                end else begin
                    state_d = ST_STEP;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                offset_d   = '0;
                moving_d   = 1'b0;
                coll_req_d = 1'b0;
            end
        endcase

        case (dir_q)
            DIR_LEFT:  begin pos_x_d = base_x_s - off_ext_s; pos_y_d = base_y_s;             end
            DIR_RIGHT: begin pos_x_d = base_x_s + off_ext_s; pos_y_d = base_y_s;             end
            DIR_UP:    begin pos_x_d = base_x_s;             pos_y_d = base_y_s - off_ext_s; end
            DIR_DOWN:  begin pos_x_d = base_x_s;             pos_y_d = base_y_s + off_ext_s; end
            default:   begin pos_x_d = base_x_s;             pos_y_d = base_y_s;             end
        endcase

        if (state_q == ST_STEP) begin
            walk_d = offset_q[OFF_W-1 -: 2];
        end else begin
            walk_d = 2'b00;
        end
    end

    // State, counter and output registers; async reset abandons any lookup.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= ST_IDLE;
            tile_x_q   <= 6'(START_X);
            tile_y_q   <= 5'(START_Y);
            tgt_x_q    <= 6'(START_X);
            tgt_y_q    <= 5'(START_Y);
            offset_q   <= '0;
            dir_q      <= DIR_DOWN;
            moving_q   <= 1'b0;
            coll_req_q <= 1'b0;
            pos_x_q    <= 10'(START_X * STEP_PIXELS);
            pos_y_q    <= 10'(START_Y * STEP_PIXELS);
            walk_q     <= 2'b00;
        end else begin
            state_q    <= state_d;
            tile_x_q   <= tile_x_d;
            tile_y_q   <= tile_y_d;
            tgt_x_q    <= tgt_x_d;
            tgt_y_q    <= tgt_y_d;
            offset_q   <= offset_d;
            dir_q      <= dir_d;
            moving_q   <= moving_d;
            coll_req_q <= coll_req_d;
            pos_x_q    <= pos_x_d;
            pos_y_q    <= pos_y_d;
            walk_q     <= walk_d;
        end
    end

    assign coll.coll_req    = coll_req_q;
    assign coll.coll_x      = tgt_x_q;
    assign coll.coll_y      = tgt_y_q;
    assign tile_x           = tile_x_q;
    assign tile_y           = tile_y_q;
    assign pos_x            = pos_x_q;
    assign pos_y            = pos_y_q;
    assign Direction        = dir_q;
    assign Character_Moving = moving_q;
    assign walk_frame       = walk_q;

endmodule

// File: tb/tb_overworld_step_ctrl.sv
// Randomised and directed bench for overworld_step_ctrl against a frame-level
// behavioural model of the tile-stepping rules.
module tb_overworld_step_ctrl;

    localparam int TILE = 16;
    localparam int SX   = 10;
    localparam int SY   = 7;

    logic       Clk;
    logic       Reset_n;
    logic       vs;
    logic [7:0] keycode;
    logic [5:0] tile_x;
    logic [4:0] tile_y;
    logic [9:0] pos_x;
    logic [9:0] pos_y;
    logic [1:0] Direction;
    logic       Character_Moving;
    logic [1:0] walk_frame;

    overworld_step_ctrl_if cif();

    overworld_step_ctrl dut (
        .Clk              (Clk),
        .Reset_n          (Reset_n),
        .vs               (vs),
        .keycode          (keycode),
        .coll             (cif),
        .tile_x           (tile_x),
        .tile_y           (tile_y),
        .pos_x            (pos_x),
        .pos_y            (pos_y),
        .Direction        (Direction),
        .Character_Moving (Character_Moving),
        .walk_frame       (walk_frame)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 0;
    int req_cnt = 0;
    int mov_cnt = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Frame generator: 8-cycle frames, sync low for 2 cycles.
    int vcnt = 0;
    initial vs = 1'b1;
    always @(negedge Clk) begin
        #1;
        vcnt = (vcnt + 1) % 8;
        vs = (vcnt < 2) ? 1'b0 : 1'b1;
    end

    // Collision responder: 0 random, 1 free with fixed delay, 2 blocked with fixed delay, 3 never answers.
    int resp_mode = 1;
    int resp_delay = 0;
    int late_ack_req = 0;
    int late_ack_done = 0;
    bit req_seen;
    bit ack_issued = 0;
    int wait_left = 0;
    bit blk_pick = 0;
    always @(negedge Clk) begin
        req_seen = cif.coll_req;
        #1;
        cif.coll_ack = 1'b0;
        cif.coll_blocked = 1'($urandom_range(0, 1));
        if (late_ack_req != late_ack_done) begin
            cif.coll_ack = 1'b1;
            cif.coll_blocked = 1'b0;
            late_ack_done++;
        end else if (req_seen && !ack_issued && resp_mode != 3) begin
            if (wait_left == 0) begin
                cif.coll_ack = 1'b1;
                cif.coll_blocked = blk_pick;
                ack_issued = 1;
            end else begin
                wait_left--;
            end
        end
        if (!req_seen) begin
            ack_issued = 0;
            wait_left = (resp_mode == 0) ? int'($urandom_range(0, 3)) : resp_delay;
            blk_pick = (resp_mode == 2) ? 1'b1 : (resp_mode == 0) ? ($urandom_range(0, 3) == 0) : 1'b0;
        end
    end

    function automatic int key_dir(input logic [7:0] kc);
        if (kc == 8'h1A) return 1;
        if (kc == 8'h16) return 0;
        if (kc == 8'h04) return 2;
        if (kc == 8'h07) return 3;
        return -1;
    endfunction

    // Behavioural model: phase 0 idle, 1 awaiting lookup, 2 walking.
    int m_phase, m_tx, m_ty, m_dir, m_off, m_gx, m_gy;
    bit m_req, m_mov;
    int e_px, e_py, e_wf;
    bit h[4];
    bit tk;
    int kd, nx, ny;
    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            m_phase = 0; m_tx = SX; m_ty = SY; m_dir = 0; m_off = 0;
            m_gx = SX; m_gy = SY; m_req = 0; m_mov = 0;
            e_px = SX * TILE; e_py = SY * TILE; e_wf = 0;
            for (int i = 0; i < 4; i++) h[i] = 1'b1;
        end else begin
            // A tick acts on the FSM 3 clocks after vs is first seen high.
            tk = h[2] && !h[3];
            h[3] = h[2]; h[2] = h[1]; h[1] = h[0]; h[0] = vs;
            e_px = m_tx * TILE + ((m_dir == 2) ? -m_off : (m_dir == 3) ? m_off : 0);
            e_py = m_ty * TILE + ((m_dir == 1) ? -m_off : (m_dir == 0) ? m_off : 0);
            e_wf = (m_phase == 2) ? m_off / (TILE / 4) : 0;
            if (m_phase == 0) begin
                if (tk) begin
                    kd = key_dir(keycode);
                    if (kd >= 0) begin
                        m_dir = kd;
                        nx = m_tx + ((kd == 2) ? -1 : (kd == 3) ? 1 : 0);
                        ny = m_ty + ((kd == 1) ? -1 : (kd == 0) ? 1 : 0);
                        if (nx >= 0 && nx < 40 && ny >= 0 && ny < 30) begin
                            m_gx = nx; m_gy = ny; m_phase = 1; m_req = 1;
                        end
                    end
                end
            end else if (m_phase == 1) begin
                if (cif.coll_ack === 1'b1) begin
                    m_req = 0;
                    if (cif.coll_blocked) m_phase = 0;
                    else begin m_phase = 2; m_off = 0; m_mov = 1; end
                end
            end else begin
                if (tk) begin
                    m_off++;
                    if (m_off == TILE) begin
                        m_tx = m_gx; m_ty = m_gy; m_off = 0; m_mov = 0; m_phase = 0;
                    end
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge Clk) begin
        if (chk_en) begin
            check("coll_req", int'(cif.coll_req), int'(m_req));
            if (m_req) begin
                check("coll_x", int'(cif.coll_x), m_gx);
                check("coll_y", int'(cif.coll_y), m_gy);
            end
            check("tile_x", int'(tile_x), m_tx);
            check("tile_y", int'(tile_y), m_ty);
            check("pos_x", int'(pos_x), e_px);
            check("pos_y", int'(pos_y), e_py);
            check("Direction", int'(Direction), m_dir);
            check("Character_Moving", int'(Character_Moving), int'(m_mov));
            check("walk_frame", int'(walk_frame), e_wf);
        end
        if (cif.coll_req) req_cnt++;
        if (Character_Moving) mov_cnt++;
    end

    task automatic step();
        @(negedge Clk);
        #2;
    endtask

    task automatic wait_req(input int lim, input string nm);
        for (int k = 0; k < lim && !cif.coll_req; k++) step();
        check(nm, int'(cif.coll_req), 1);
    endtask

    task automatic wait_moving(input bit val, input int lim, input string nm);
        for (int k = 0; k < lim && Character_Moving != val; k++) step();
        check(nm, int'(Character_Moving), int'(val));
    endtask

    int wf_lit[16] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3};
    logic [7:0] keys[6] = '{8'h1A, 8'h16, 8'h04, 8'h07, 8'h00, 8'h2C};
    int prev, nchg, r0, m0;

    initial begin
        Reset_n = 1'b0;
        keycode = 8'h00;
        repeat (3) step();
        chk_en = 1;
        Reset_n = 1'b1;

        // Idle for 5 frames with no key.
        r0 = req_cnt;
        repeat (40) step();
        check("idle_tile_x", int'(tile_x), 10);
        check("idle_tile_y", int'(tile_y), 7);
        check("idle_pos_x", int'(pos_x), 160);
        check("idle_pos_y", int'(pos_y), 112);
        check("idle_dir", int'(Direction), 0);
        check("idle_no_req", req_cnt - r0, 0);

        // Step right, lookup acked unblocked after 3 clocks.
        resp_mode = 1; resp_delay = 3;
        keycode = 8'h07;
        wait_req(40, "right_req_timeout");
        check("right_coll_x", int'(cif.coll_x), 11);
        check("right_coll_y", int'(cif.coll_y), 7);
        keycode = 8'h00;
        wait_moving(1'b1, 20, "right_move_timeout");
        prev = int'(pos_x); nchg = 0;
        for (int k = 0; k < 400 && Character_Moving; k++) begin
            step();
            if (int'(pos_x) != prev) begin
                nchg++;
                check("right_pos_inc", int'(pos_x), prev + 1);
                if (pos_x > 10'd160 && pos_x < 10'd176)
                    check("right_walk_seq", int'(walk_frame), wf_lit[int'(pos_x) - 160]);
                prev = int'(pos_x);
            end
        end
        check("right_pos_steps", nchg, 15);
        step();
        check("right_end_pos_x", int'(pos_x), 176);
        check("right_end_tile_x", int'(tile_x), 11);

        // Step up into a blocked tile: turn only.
        resp_mode = 2; resp_delay = 1;
        keycode = 8'h1A;
        wait_req(40, "up_req_timeout");
        keycode = 8'h00;
        m0 = mov_cnt;
        repeat (30) step();
        check("up_dir", int'(Direction), 1);
        check("up_never_moving", mov_cnt - m0, 0);
        check("up_tile_x", int'(tile_x), 11);
        check("up_tile_y", int'(tile_y), 7);

        // Walk left to the map edge, then keep pushing.
        resp_mode = 1; resp_delay = 0;
        keycode = 8'h04;
        for (int k = 0; k < 4000 && tile_x != 6'd0; k++) step();
        check("left_reach_edge", int'(tile_x), 0);
        r0 = req_cnt;
        repeat (40) step();
        check("edge_no_req", req_cnt - r0, 0);
        check("edge_dir", int'(Direction), 2);
        check("edge_tile_x", int'(tile_x), 0);

        // Key changes to down mid-step; step finishes right, next step goes down.
        keycode = 8'h07;
        wait_moving(1'b1, 60, "mid_move_timeout");
        repeat (30) step();
        keycode = 8'h16;
        wait_moving(1'b0, 300, "mid_end_timeout");
        check("mid_tile_x", int'(tile_x), 1);
        check("mid_dir", int'(Direction), 3);
        wait_moving(1'b1, 60, "down_move_timeout");
        check("down_dir", int'(Direction), 0);
        keycode = 8'h00;
        wait_moving(1'b0, 300, "down_end_timeout");
        check("down_tile_y", int'(tile_y), 8);

        // Reset during a pending lookup, then a stray late ack.
        resp_mode = 3;
        keycode = 8'h07;
        wait_req(40, "rst_req_timeout");
        Reset_n = 1'b0;
        #1;
        check("rstq_coll_req", int'(cif.coll_req), 0);
        check("rstq_tile_x", int'(tile_x), 10);
        check("rstq_tile_y", int'(tile_y), 7);
        check("rstq_pos_x", int'(pos_x), 160);
        check("rstq_pos_y", int'(pos_y), 112);
        keycode = 8'h00;
        repeat (2) step();
        Reset_n = 1'b1;
        late_ack_req++;
        repeat (4) step();
        check("late_ack_req", int'(cif.coll_req), 0);
        check("late_ack_moving", int'(Character_Moving), 0);
        check("late_ack_tile", int'(tile_x), 10);

        // Reset at offset 9 of a step.
        resp_mode = 1; resp_delay = 2;
        keycode = 8'h07;
        for (int k = 0; k < 400 && pos_x != 10'd169; k++) step();
        check("rsts_reach_169", int'(pos_x), 169);
        Reset_n = 1'b0;
        #1;
        check("rsts_tile_x", int'(tile_x), 10);
        check("rsts_pos_x", int'(pos_x), 160);
        check("rsts_moving", int'(Character_Moving), 0);
        check("rsts_walk", int'(walk_frame), 0);
        keycode = 8'h00;
        repeat (2) step();
        Reset_n = 1'b1;

        // Random keys and random collision answers.
        resp_mode = 0;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 24) == 0) keycode = keys[$urandom_range(0, 5)];
            step();
        end
        keycode = 8'h00;
        repeat (200) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
